// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester (ADMA, host) burst arbiter for the shared system RAM port
// Build macro: RAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed ADMA priority.
module ram_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              adma_req,
  input  logic              adma_write,
  input  logic [ADDR_W-1:0] adma_address,
  input  logic [DATA_W-1:0] adma_data_in,
  input  logic [7:0]        adma_burst,
  output logic              adma_grant,
  output logic              adma_ack,
  output logic [DATA_W-1:0] adma_data_out,
  input  logic              host_req,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_address,
  input  logic [DATA_W-1:0] host_data_in,
  input  logic [7:0]        host_burst,
  output logic              host_grant,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_data_out,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write,
  output logic              ram_read,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        owner_host, owner_host_nxt;
  logic [8:0]  beat_cnt, beat_cnt_nxt;
  logic        drain_cnt, drain_cnt_nxt;
  logic        win_host;
  logic        owner_req;
  logic        beat_acc;
  logic        sel_write;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_data;

  logic p1_vld, p1_host, p1_read;
  logic p2_vld, p2_host, p2_read;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // 0 means the host won the last grant, so ADMA is favoured next
  logic last_adma;

  assign win_host = host_req && (!adma_req || last_adma);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_adma <= 1'b0;
    end else if (state == IDLE && (adma_req || host_req)) begin
      last_adma <= !win_host;
    end
  end
`else
  assign win_host = host_req && !adma_req;
`endif

  assign owner_req   = owner_host ? host_req : adma_req;
  assign beat_acc    = (state == ACCESS) && owner_req;
  assign adma_grant  = (state == ACCESS) && !owner_host;
  assign host_grant  = (state == ACCESS) && owner_host;
  assign sel_write   = owner_host ? host_write   : adma_write;
  assign sel_address = owner_host ? host_address : adma_address;
  assign sel_data    = owner_host ? host_data_in : adma_data_in;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      owner_host <= 1'b0;
      beat_cnt   <= 9'd0;
      drain_cnt  <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner_host <= owner_host_nxt;
      beat_cnt   <= beat_cnt_nxt;
      drain_cnt  <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_host_nxt = owner_host;
    beat_cnt_nxt   = beat_cnt;
    drain_cnt_nxt  = drain_cnt;
    case (state)
      IDLE: begin
        if (adma_req || host_req) begin
          state_nxt      = ACCESS;
          owner_host_nxt = win_host;
          beat_cnt_nxt   = win_host ? ({1'b0, host_burst} + 9'd1)
                                    : ({1'b0, adma_burst} + 9'd1);
        end
      end
      ACCESS: begin
        // A low owner req stalls the burst; the grant is never timed out
        if (beat_acc) begin
          beat_cnt_nxt = beat_cnt - 9'd1;
          if (beat_cnt == 9'd1) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt) begin
          state_nxt     = IDLE;
          drain_cnt_nxt = 1'b0;
        end else begin
          drain_cnt_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ram_address <= '0;
      ram_data_in <= '0;
      ram_write   <= 1'b0;
      ram_read    <= 1'b0;
    end else begin
      ram_write <= beat_acc && sel_write;
      ram_read  <= beat_acc && !sel_write;
      if (beat_acc) begin
        ram_address <= sel_address;
        ram_data_in <= sel_data;
      end
    end
  end

  // Owner tag travels two stages; read data is sampled the cycle after ram_read
  always_ff @(posedge CLK) begin
    if (RESET) begin
      p1_vld        <= 1'b0;
      p1_host       <= 1'b0;
      p1_read       <= 1'b0;
      p2_vld        <= 1'b0;
      p2_host       <= 1'b0;
      p2_read       <= 1'b0;
      adma_ack      <= 1'b0;
      host_ack      <= 1'b0;
      adma_data_out <= '0;
      host_data_out <= '0;
    end else begin
      p1_vld   <= beat_acc;
      p1_host  <= owner_host;
      p1_read  <= !sel_write;
      p2_vld   <= p1_vld;
      p2_host  <= p1_host;
      p2_read  <= p1_read;
      adma_ack <= p2_vld && !p2_host;
      host_ack <= p2_vld && p2_host;
      if (p2_vld && p2_read && !p2_host) begin
        adma_data_out <= ram_data_out;
      end
      if (p2_vld && p2_read && p2_host) begin
        host_data_out <= ram_data_out;
      end
    end
  end

endmodule
